// File: rtl/gpu_pkg.sv
// gpu_pkg: shared coordinate types, shape IDs, shape-0 vertex table and streamer FSM states
package gpu_pkg;
    localparam int COORD_W_DEF = 16;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;
    localparam int SHAPE_PYRAMID = 0;
    localparam int SHAPE_RSVD1 = 1;
    localparam int SHAPE_RSVD2 = 2;
    localparam int SHAPE_RSVD3 = 3;
    localparam int SHAPE0_COUNT = 4;
    localparam vertex_t SHAPE0_V0 = '{x: 16'h0000, y: 16'h0000, z: 16'h0330};
    localparam vertex_t SHAPE0_V1 = '{x: 16'hFFFF, y: 16'hFDBF, z: 16'hFCD0};
    localparam vertex_t SHAPE0_V2 = '{x: 16'h0001, y: 16'hFDBF, z: 16'hFCD0};
    localparam vertex_t SHAPE0_V3 = '{x: 16'h0000, y: 16'h0483, z: 16'hFCD0};
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/shape_rom.sv
// shape_rom: combinational shape/index lookup returning sign-extended vertex and vertex count
module shape_rom
    import gpu_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int MAX_VERTS = 12,
    parameter int SHAPE_W = 2,
    parameter int IW = $clog2(MAX_VERTS),
    parameter int CW = $clog2(MAX_VERTS + 1)
) (
    input  logic [SHAPE_W-1:0]   shape,
    input  logic [IW-1:0]        idx,
    output logic [3*COORD_W-1:0] vert,
    output logic [CW-1:0]        count
);
    function automatic logic [COORD_W-1:0] ext(input logic [15:0] c);
        return COORD_W'($signed(c));
    endfunction
    if (SHAPE0_COUNT > MAX_VERTS) begin : g_chk
        $error("shape table vertex count exceeds MAX_VERTS");
    end
    vertex_t v;
    logic    hit;
    always_comb begin
        v = (idx == IW'(0)) ? SHAPE0_V0 :
            (idx == IW'(1)) ? SHAPE0_V1 :
            (idx == IW'(2)) ? SHAPE0_V2 : SHAPE0_V3;
        hit = (shape == SHAPE_W'(SHAPE_PYRAMID));
        count = hit ? CW'(SHAPE0_COUNT) : '0;
        vert = (hit && idx < IW'(SHAPE0_COUNT)) ? {ext(v.x), ext(v.y), ext(v.z)} : '0;
    end
endmodule

// File: rtl/shape_vertex_streamer.sv
// shape_vertex_streamer: streams a shape's translated vertices over a valid/ready handshake
module shape_vertex_streamer
    import gpu_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int MAX_VERTS = 12,
    parameter int SHAPE_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [SHAPE_W-1:0]           shape_sel,
    input  logic [3*COORD_W-1:0]         offset,
    output logic                         busy,
    output logic                         vert_valid,
    input  logic                         vert_ready,
    output logic [3*COORD_W-1:0]         vert_data,
    output logic [$clog2(MAX_VERTS)-1:0] vert_idx,
    output logic                         vert_last,
    output logic                         done
);
    localparam int IW = $clog2(MAX_VERTS);
    localparam int CW = $clog2(MAX_VERTS + 1);
    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [SHAPE_W-1:0]   shape_q, rom_shape;
    logic [3*COORD_W-1:0] offset_q, rom_vert;
    logic [CW-1:0]        count;
    logic                 accept, hs, last;
    assign rom_shape = (state == IDLE) ? shape_sel : shape_q;
    shape_rom #(
        .COORD_W(COORD_W),
        .MAX_VERTS(MAX_VERTS),
        .SHAPE_W(SHAPE_W),
        .IW(IW),
        .CW(CW)
    ) u_rom (
        .shape(rom_shape),
        .idx(idx),
        .vert(rom_vert),
        .count(count)
    );
    assign busy = (state != IDLE);
    assign vert_valid = (state == STREAM);
    assign done = (state == DONE);
    assign vert_idx = vert_valid ? idx : '0;
    assign vert_last = vert_valid & last;
    for (genvar g = 0; g < 3; g++) begin : g_axis
        assign vert_data[g*COORD_W +: COORD_W] = vert_valid ?
            rom_vert[g*COORD_W +: COORD_W] + offset_q[g*COORD_W +: COORD_W] : '0;
    end
    always_comb begin
        accept = (state == IDLE) && start;
        hs = vert_valid && vert_ready;
        last = (CW'(idx) == count - CW'(1));
        state_n = state;
        idx_n = idx;
        if (accept) begin
            state_n = (count != '0) ? STREAM : DONE;
            idx_n = '0;
        end else if (hs) begin
            state_n = last ? DONE : STREAM;
            idx_n = last ? idx : idx + IW'(1);
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            shape_q <= '0;
            offset_q <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            shape_q <= accept ? shape_sel : shape_q;
            offset_q <= accept ? offset : offset_q;
        end
    end
endmodule
